wb_fwd_pipe: RTL and testbench
==============================

# wb_fwd_pipe

Parametrised write-back path for the pipelined CPU.
- Replaces the combinational destination-select and write-data-select muxes with a three-stage E/M/W tracking pipeline.
- Decides each instruction's destination register and data source at issue and carries them down the pipe.
- Drives the GRF write port from the W stage.
- Provides decode-stage operand forwarding for two source registers and a stall request on load-use or ALU-use hazards.

## Interface
Parameters:
- WIDTH, 32, data width
- AW, 5, register address width
- LINK_REG, 31, register written when dst_sel = 2'b10
- PC_OFFSET, 8, added to `pc` for link data

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- issue  in  1  D-stage instruction valid to enter E this cycle
- flush  in  1  force bubble into E this cycle
- dst_sel  in  2  00 rt_addr, 01 rd_addr, 10 LINK_REG, 11 no write
- wd_sel  in  2  00 ALU, 01 memory, 10 pc+PC_OFFSET, 11 no write
- rt_addr, rd_addr  in  AW  destination candidates of the D-stage instruction
- pc  in  WIDTH  PC of the D-stage instruction
- e_alu  in  WIDTH  ALU result of the instruction currently in E
- m_mem  in  WIDTH  memory read data of the instruction currently in M
- rs_rd, rt_rd  in  AW  D-stage source register addresses
- rs_grf, rt_grf  in  WIDTH  GRF read data for rs_rd / rt_rd
- rs_fwd, rt_fwd  out  WIDTH  forwarded operands
- stall_req  out  1  D must hold; E captures a bubble
- grf_we  out  1  GRF write enable
- grf_addr  out  AW  GRF write address
- grf_wd  out  WIDTH  GRF write data

## Operation
Per-stage register contents:
- valid, addr (AW), sel (2), data (WIDTH).
- Tnew (2-bit) is derived from stage and sel.

E capture (every cycle):
- Capture is valid when issue & ~flush & ~stall_req & dst_sel≠11 & wd_sel≠11 & resolved addr≠0. Otherwise E captures a bubble (valid 0).
- addr is resolved from dst_sel.
- data = pc + PC_OFFSET, truncated to WIDTH.

Advance (every cycle, no hold):
- M ← E. If E.sel = 00, M.data ← e_alu.
- W ← M. If M.sel = 01, W.data ← m_mem.

Outputs:
- grf_we = W.valid; grf_addr = W.addr; grf_wd = W.data.

Tnew:
- E stage: ALU = 1, MEM = 2, PC = 0.
- M stage: MEM = 1, others 0.
- W stage: 0.

Forwarding, per operand (rs and rt are independent):
- Scan E, then M, then W. The first valid stage with addr = src is selected.
- If the selected stage has Tnew = 0, fwd = its data. Otherwise stall_req is asserted and fwd is don't-care.
- No stage matches: fwd = GRF read data.
- src = 0 never matches.
- stall_req = OR over both operands.

Stall and flush:
- Requesting stall is the only hold mechanism here. Upstream freezes F/D while stall_req = 1.
- flush and stall_req both bubble E. They may coincide with no extra effect.

## Timing
- Reset (async, immediate): all valids 0, all addr/sel/data 0. grf_we = 0, grf_addr = 0, grf_wd = 0, stall_req = 0, rs_fwd = rs_grf, rt_fwd = rt_grf.
- Reset mid-operation discards all in-flight instructions. No GRF write occurs after reset asserts.
- Latency: an issued instruction drives grf_we exactly 3 rising edges after its issue edge.
- stall_req, rs_fwd and rt_fwd are combinational from stage registers and D inputs, valid in the same cycle.
- Load-use with the load in E: stall_req is high for 2 cycles, then the value is forwarded from W.
- ALU-use with the producer in E: 1 stall cycle, then the value is forwarded from M.
- Link (PC) producer: forwarded from E immediately, no stall.
- Youngest producer wins. E beats M beats W, even when an older stage holds a ready value.
- Same register written by W and read in D in the same cycle: the value comes from W, not the GRF.

## Test plan
- Issue ALU op, dst_sel 01, rd_addr 5, e_alu 0x1234 next cycle -> grf_we = 1, grf_addr = 5, grf_wd = 0x1234 three edges after issue.
- Load (wd_sel 01, rt_addr 8), next D reads rs_rd = 8 -> stall_req = 1 for 2 cycles, 2 bubbles in E; then m_mem 0xCAFE forwarded on rs_fwd with stall_req = 0.
- jal (dst_sel 10, wd_sel 10, pc 0x3000), next D reads rt_rd = 31 -> no stall, rt_fwd = 0x3008, then grf_addr 31 written with 0x3008.
- Back-to-back ALU writes to reg 3 (values 0x11 then 0x22), reader after 2 issues -> rs_fwd = 0x22, never 0x11.
- Destination 0, or rs_rd = 0 with GRF read data 0 -> grf_we stays 0, no stall, rs_fwd = 0.
- reset pulsed while 3 instructions are in flight -> grf_we = 0 immediately and no write on any later edge; flush with issue = 1 -> no write 3 edges later.

Source files
------------

// File: rtl/wb_fwd_pipe.sv
// wb_fwd_pipe: write-back tracking pipeline (E/M/W) for the pipelined CPU.
// The destination register and data source of each instruction are resolved
// at issue and carried down the pipe; W drives the GRF write port. The D stage
// gets forwarded rs/rt operands and a stall request on load-use / ALU-use.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   issue, flush          D instruction enters E / force a bubble into E
//   dst_sel, wd_sel       destination select / write-data source select
//   rt_addr, rd_addr, pc  D-stage destination candidates and PC
//   e_alu, m_mem          ALU result of E, memory read data of M
//   rs_rd, rt_rd          D-stage source register addresses
//   rs_grf, rt_grf        GRF read data for those sources
//   rs_fwd, rt_fwd        forwarded operands (combinational)
//   stall_req             D must hold, E captures a bubble (combinational)
//   grf_we/addr/wd        GRF write port, straight from W-stage registers
module wb_fwd_pipe #(
  parameter int WIDTH     = 32,
  parameter int AW        = 5,
  parameter int LINK_REG  = 31,
  parameter int PC_OFFSET = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue,
  input  logic             flush,
  input  logic [1:0]       dst_sel,
  input  logic [1:0]       wd_sel,
  input  logic [AW-1:0]    rt_addr,
  input  logic [AW-1:0]    rd_addr,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] e_alu,
  input  logic [WIDTH-1:0] m_mem,
  input  logic [AW-1:0]    rs_rd,
  input  logic [AW-1:0]    rt_rd,
  input  logic [WIDTH-1:0] rs_grf,
  input  logic [WIDTH-1:0] rt_grf,
  output logic [WIDTH-1:0] rs_fwd,
  output logic [WIDTH-1:0] rt_fwd,
  output logic             stall_req,
  output logic             grf_we,
  output logic [AW-1:0]    grf_addr,
  output logic [WIDTH-1:0] grf_wd
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_NONE = 2'b11;
  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_LINK = 2'b10;

  // Stage registers. W carries no sel: its data is already final.
  logic             e_valid_r, m_valid_r, w_valid_r;
  logic [AW-1:0]    e_addr_r, m_addr_r, w_addr_r;
  logic [1:0]       e_sel_r, m_sel_r;
  logic [WIDTH-1:0] e_data_r, m_data_r, w_data_r;

  logic [1:0]       e_tnew_s, m_tnew_s;
  logic [AW-1:0]    cap_addr_s;
  logic             cap_valid_s;
  logic [WIDTH-1:0] cap_data_s;
  logic [WIDTH:0]   rs_res_s, rt_res_s;

  // Forwarding lookup: returns {stall, data}. Youngest matching stage wins;
  // a match that is not yet ready (tnew != 0) requests a stall.
  function automatic logic [WIDTH:0] fwd_lookup(
    input logic [AW-1:0]    src,
    input logic [WIDTH-1:0] grf,
    input logic             ev, input logic [AW-1:0] ea,
    input logic [1:0]       et, input logic [WIDTH-1:0] ed,
    input logic             mv, input logic [AW-1:0] ma,
    input logic [1:0]       mt, input logic [WIDTH-1:0] md,
    input logic             wv, input logic [AW-1:0] wa,
    input logic [WIDTH-1:0] wdat
  );
    logic [WIDTH:0] res;
    if (src == {AW{1'b0}}) begin
      res = {1'b0, grf};
    end else if (ev && (ea == src)) begin
      res = {(et != 2'b00), ed};
    end else if (mv && (ma == src)) begin
      res = {(mt != 2'b00), md};
    end else if (wv && (wa == src)) begin
      res = {1'b0, wdat};
    end else begin
      res = {1'b0, grf};
    end
    return res;
  endfunction

  // Tnew per stage: cycles until the carried value is final.
  always_comb begin
    case (e_sel_r)
      SEL_ALU: e_tnew_s = 2'd1;
      SEL_MEM: e_tnew_s = 2'd2;
      default: e_tnew_s = 2'd0;
    endcase
    if (m_sel_r == SEL_MEM) begin
      m_tnew_s = 2'd1;
    end else begin
      m_tnew_s = 2'd0;
    end
  end

  // Operand forwarding and stall request for both D-stage sources.
  always_comb begin
    rs_res_s = fwd_lookup(rs_rd, rs_grf, e_valid_r, e_addr_r, e_tnew_s, e_data_r,
                          m_valid_r, m_addr_r, m_tnew_s, m_data_r,
                          w_valid_r, w_addr_r, w_data_r);
    rt_res_s = fwd_lookup(rt_rd, rt_grf, e_valid_r, e_addr_r, e_tnew_s, e_data_r,
                          m_valid_r, m_addr_r, m_tnew_s, m_data_r,
                          w_valid_r, w_addr_r, w_data_r);
  end

  assign rs_fwd    = rs_res_s[WIDTH-1:0];
  assign rt_fwd    = rt_res_s[WIDTH-1:0];
  assign stall_req = rs_res_s[WIDTH] | rt_res_s[WIDTH];

  // Resolve the destination of the D instruction and decide if E captures it.
  always_comb begin
    case (dst_sel)
      DST_RT:   cap_addr_s = rt_addr;
      DST_RD:   cap_addr_s = rd_addr;
      DST_LINK: cap_addr_s = AW'(LINK_REG);
      default:  cap_addr_s = {AW{1'b0}};
    endcase
    cap_data_s  = pc + WIDTH'(PC_OFFSET);
    cap_valid_s = issue & ~flush & ~stall_req & (dst_sel != SEL_NONE) &
                  (wd_sel != SEL_NONE) & (cap_addr_s != {AW{1'b0}});
  end

  // E stage: captures the issued instruction or a clean bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_valid_r <= 1'b0;
      e_addr_r  <= {AW{1'b0}};
      e_sel_r   <= 2'b00;
      e_data_r  <= {WIDTH{1'b0}};
    end else if (cap_valid_s) begin
      e_valid_r <= 1'b1;
      e_addr_r  <= cap_addr_s;
      e_sel_r   <= wd_sel;
      e_data_r  <= cap_data_s;
    end else begin
      e_valid_r <= 1'b0;
      e_addr_r  <= {AW{1'b0}};
      e_sel_r   <= 2'b00;
      e_data_r  <= {WIDTH{1'b0}};
    end
  end

  // M stage: ALU results are picked up as the instruction leaves E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_r <= 1'b0;
      m_addr_r  <= {AW{1'b0}};
      m_sel_r   <= 2'b00;
      m_data_r  <= {WIDTH{1'b0}};
    end else begin
      m_valid_r <= e_valid_r;
      m_addr_r  <= e_addr_r;
      m_sel_r   <= e_sel_r;
      m_data_r  <= (e_sel_r == SEL_ALU) ? e_alu : e_data_r;
    end
  end

  // W stage: load data is picked up as the instruction leaves M.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid_r <= 1'b0;
      w_addr_r  <= {AW{1'b0}};
      w_data_r  <= {WIDTH{1'b0}};
    end else begin
      w_valid_r <= m_valid_r;
      w_addr_r  <= m_addr_r;
      w_data_r  <= (m_sel_r == SEL_MEM) ? m_mem : m_data_r;
    end
  end

  assign grf_we   = w_valid_r;
  assign grf_addr = w_addr_r;
  assign grf_wd   = w_data_r;

endmodule

// File: tb/tb_wb_fwd_pipe.sv
module tb_wb_fwd_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue, flush;
  logic [1:0]  dst_sel, wd_sel;
  logic [4:0]  rt_addr, rd_addr, rs_rd, rt_rd;
  logic [31:0] pc, e_alu, m_mem, rs_grf, rt_grf;
  logic [31:0] rs_fwd, rt_fwd;
  logic        stall_req, grf_we;
  logic [4:0]  grf_addr;
  logic [31:0] grf_wd;

  always #5 clk = ~clk;

  wb_fwd_pipe #(.WIDTH(32), .AW(5), .LINK_REG(31), .PC_OFFSET(8)) dut (
    .clk(clk), .reset(reset), .issue(issue), .flush(flush),
    .dst_sel(dst_sel), .wd_sel(wd_sel), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .pc(pc), .e_alu(e_alu), .m_mem(m_mem), .rs_rd(rs_rd), .rt_rd(rt_rd),
    .rs_grf(rs_grf), .rt_grf(rt_grf), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd),
    .stall_req(stall_req), .grf_we(grf_we), .grf_addr(grf_addr), .grf_wd(grf_wd)
  );

  typedef struct {
    logic        issue, flush;
    logic [1:0]  dst_sel, wd_sel;
    logic [4:0]  rt_addr, rd_addr;
    logic [31:0] pc, alu, mem;
    logic [4:0]  rs_rd, rt_rd;
    logic [31:0] rs_grf, rt_grf;
    logic        exp_stall;
    logic [31:0] exp_rs, exp_rt;
  } vec_t;

  typedef struct {
    int          due;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  localparam int NV = 24;
  vec_t        vecs [NV];
  wr_t         sb [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] prev_mem = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Write-port monitor: every cycle either the scheduled write or no write.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("wr_we", {31'd0, grf_we}, 32'd1);
      chk("wr_addr", {27'd0, grf_addr}, {27'd0, sb[0].addr});
      chk("wr_data", grf_wd, sb[0].data);
      sb.delete(0);
    end else begin
      chk("no_wr", {31'd0, grf_we}, 32'd0);
    end
  end

  function automatic vec_t mk(
    input logic is, input logic fl, input logic [1:0] ds, input logic [1:0] ws,
    input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] p,
    input logic [31:0] al, input logic [31:0] me,
    input logic [4:0] rsr, input logic [4:0] rtr,
    input logic [31:0] rsg, input logic [31:0] rtg,
    input logic st, input logic [31:0] ers, input logic [31:0] ert);
    vec_t v;
    v.issue = is; v.flush = fl; v.dst_sel = ds; v.wd_sel = ws;
    v.rt_addr = rt; v.rd_addr = rd; v.pc = p; v.alu = al; v.mem = me;
    v.rs_rd = rsr; v.rt_rd = rtr; v.rs_grf = rsg; v.rt_grf = rtg;
    v.exp_stall = st; v.exp_rs = ers; v.exp_rt = ert;
    return v;
  endfunction

  // Drive one D-stage cycle, check comb outputs, schedule the expected write.
  task automatic drive(input vec_t v, input int idx);
    logic [4:0]  a;
    logic [31:0] d;
    wr_t         w;
    issue = v.issue; flush = v.flush; dst_sel = v.dst_sel; wd_sel = v.wd_sel;
    rt_addr = v.rt_addr; rd_addr = v.rd_addr; pc = v.pc;
    rs_rd = v.rs_rd; rt_rd = v.rt_rd; rs_grf = v.rs_grf; rt_grf = v.rt_grf;
    #2;
    chk($sformatf("v%0d_stall", idx), {31'd0, stall_req}, {31'd0, v.exp_stall});
    if (!v.exp_stall) begin
      chk($sformatf("v%0d_rs_fwd", idx), rs_fwd, v.exp_rs);
      chk($sformatf("v%0d_rt_fwd", idx), rt_fwd, v.exp_rt);
    end
    case (v.dst_sel)
      2'b00:   a = v.rt_addr;
      2'b01:   a = v.rd_addr;
      2'b10:   a = 5'd31;
      default: a = 5'd0;
    endcase
    case (v.wd_sel)
      2'b00:   d = v.alu;
      2'b01:   d = v.mem;
      2'b10:   d = v.pc + 32'd8;
      default: d = 32'd0;
    endcase
    if (v.issue && !v.flush && !v.exp_stall && v.dst_sel != 2'b11 &&
        v.wd_sel != 2'b11 && a != 5'd0) begin
      w.due = cyc + 3; w.addr = a; w.data = d;
      sb.push_back(w);
    end
    @(posedge clk);
    #1;
    e_alu    = v.alu;
    m_mem    = prev_mem;
    prev_mem = v.mem;
  endtask

  initial begin
    vec_t idle_v;
    // ALU write to r5, then reader: 1 stall, forward from M, then from W
    vecs[0]  = mk(1'b1, 1'b0, 2'b01, 2'b00, 5'd0, 5'd5, 32'h100, 32'h1234, 32'h0,
                  5'd7, 5'd0, 32'hAAAA0000, 32'h55, 1'b0, 32'hAAAA0000, 32'h55);
    vecs[1]  = mk(1'b1, 1'b0, 2'b11, 2'b00, 5'd0, 5'd0, 32'h104, 32'h0, 32'h0,
                  5'd5, 5'd0, 32'hDEAD, 32'h0, 1'b1, 32'h0, 32'h0);
    vecs[2]  = mk(1'b1, 1'b0, 2'b11, 2'b00, 5'd0, 5'd0, 32'h104, 32'h0, 32'h0,
                  5'd5, 5'd0, 32'hDEAD, 32'h0, 1'b0, 32'h1234, 32'h0);
    vecs[3]  = mk(1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                  5'd5, 5'd0, 32'hDEAD, 32'h0, 1'b0, 32'h1234, 32'h0);
    // load to r8, reader: 2 stalls, then load data from W
    vecs[4]  = mk(1'b1, 1'b0, 2'b00, 2'b01, 5'd8, 5'd0, 32'h200, 32'h0, 32'hCAFE,
                  5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[5]  = mk(1'b1, 1'b0, 2'b11, 2'b00, 5'd0, 5'd0, 32'h204, 32'h0, 32'h0,
                  5'd8, 5'd0, 32'h0BAD, 32'h0, 1'b1, 32'h0, 32'h0);
    vecs[6]  = vecs[5];
    vecs[7]  = mk(1'b1, 1'b0, 2'b11, 2'b00, 5'd0, 5'd0, 32'h204, 32'h0, 32'h0,
                  5'd8, 5'd0, 32'h0BAD, 32'h0, 1'b0, 32'hCAFE, 32'h0);
    // jal: link value forwarded from E with no stall
    vecs[8]  = mk(1'b1, 1'b0, 2'b10, 2'b10, 5'd0, 5'd0, 32'h3000, 32'h0, 32'h0,
                  5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[9]  = mk(1'b1, 1'b0, 2'b11, 2'b00, 5'd0, 5'd0, 32'h3004, 32'h0, 32'h0,
                  5'd8, 5'd31, 32'h77, 32'h0BAD, 1'b0, 32'h77, 32'h3008);
    // back-to-back writes to r3: youngest wins
    vecs[10] = mk(1'b1, 1'b0, 2'b01, 2'b00, 5'd0, 5'd3, 32'h300, 32'h11, 32'h0,
                  5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[11] = mk(1'b1, 1'b0, 2'b01, 2'b00, 5'd0, 5'd3, 32'h304, 32'h22, 32'h0,
                  5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[12] = mk(1'b1, 1'b0, 2'b11, 2'b00, 5'd0, 5'd0, 32'h308, 32'h0, 32'h0,
                  5'd3, 5'd0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
    vecs[13] = mk(1'b1, 1'b0, 2'b11, 2'b00, 5'd0, 5'd0, 32'h308, 32'h0, 32'h0,
                  5'd3, 5'd0, 32'h0, 32'h0, 1'b0, 32'h22, 32'h0);
    vecs[14] = mk(1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                  5'd3, 5'd0, 32'h0, 32'h0, 1'b0, 32'h22, 32'h0);
    // destination r0 and source r0
    vecs[15] = mk(1'b1, 1'b0, 2'b01, 2'b00, 5'd0, 5'd0, 32'h400, 32'h99, 32'h0,
                  5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[16] = mk(1'b1, 1'b0, 2'b11, 2'b00, 5'd0, 5'd0, 32'h404, 32'h0, 32'h0,
                  5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    // wd_sel = 11 never writes, flush bubbles E
    vecs[17] = mk(1'b1, 1'b0, 2'b01, 2'b11, 5'd0, 5'd9, 32'h500, 32'h0, 32'h0,
                  5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[18] = mk(1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                  5'd9, 5'd0, 32'h5, 32'h0, 1'b0, 32'h5, 32'h0);
    vecs[19] = mk(1'b1, 1'b1, 2'b01, 2'b00, 5'd0, 5'd10, 32'h600, 32'h44, 32'h0,
                  5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[20] = mk(1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                  5'd10, 5'd0, 32'h6, 32'h0, 1'b0, 32'h6, 32'h0);
    // PC data to rt_addr destination, forwarded from E on the rt operand too
    vecs[21] = mk(1'b1, 1'b0, 2'b00, 2'b10, 5'd20, 5'd0, 32'h40, 32'h0, 32'h0,
                  5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[22] = mk(1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                  5'd20, 5'd20, 32'h1, 32'h2, 1'b0, 32'h48, 32'h48);
    vecs[23] = mk(1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0,
                  5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    idle_v = vecs[23];

    // reset state
    reset = 1'b1; issue = 1'b0; flush = 1'b0; dst_sel = 2'b00; wd_sel = 2'b00;
    rt_addr = 5'd0; rd_addr = 5'd0; pc = 32'd0; e_alu = 32'd0; m_mem = 32'd0;
    rs_rd = 5'd5; rt_rd = 5'd6; rs_grf = 32'h11112222; rt_grf = 32'h33334444;
    @(negedge clk);
    @(negedge clk);
    chk("rst_we", {31'd0, grf_we}, 32'd0);
    chk("rst_addr", {27'd0, grf_addr}, 32'd0);
    chk("rst_wd", grf_wd, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_rs_fwd", rs_fwd, 32'h11112222);
    chk("rst_rt_fwd", rt_fwd, 32'h33334444);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) drive(vecs[i], i);
    for (int i = 0; i < 3; i++) drive(idle_v, 100 + i);

    // reset with three instructions in flight
    drive(mk(1'b1, 1'b0, 2'b01, 2'b00, 5'd0, 5'd12, 32'h700, 32'hA1, 32'h0,
             5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0), 200);
    drive(mk(1'b1, 1'b0, 2'b01, 2'b00, 5'd0, 5'd13, 32'h704, 32'hA2, 32'h0,
             5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0), 201);
    drive(mk(1'b1, 1'b0, 2'b01, 2'b00, 5'd0, 5'd14, 32'h708, 32'hA3, 32'h0,
             5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0), 202);
    issue = 1'b0;
    rs_rd = 5'd14; rs_grf = 32'h1357;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midrst_we", {31'd0, grf_we}, 32'd0);
    chk("midrst_addr", {27'd0, grf_addr}, 32'd0);
    chk("midrst_stall", {31'd0, stall_req}, 32'd0);
    chk("midrst_rs_fwd", rs_fwd, 32'h1357);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) drive(idle_v, 300 + i);

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
